// File: rtl/rom_loader.sv
// Instruction-ROM loader: frames a byte stream as a LE word count plus LE words and writes
// them into the ROM from address 0, holding the core in reset until a load completes.
module rom_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [CntW-1:0]   len_q, len_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;

  logic              byte_ready_q, byte_ready_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_waddr_q, rom_waddr_d;
  logic [31:0]       rom_wdata_q, rom_wdata_d;
  logic              core_hold_q, core_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic              last_byte;
  logic              last_word;
  logic              hdr_bad;
  logic              start_ok;
  logic [31:0]       asm_word;

  assign accept    = byte_valid && byte_ready_q;
  assign last_byte = accept && (byte_cnt_q == 2'd3);
  // Incoming byte lands in the top lane so byte 0 ends up in bits 7:0 after four shifts.
  assign asm_word  = {byte_data, shift_q[31:8]};
  assign hdr_bad   = (asm_word == 32'd0) || (asm_word > 32'(DEPTH));
  assign last_word = (word_cnt_q == (len_q - CntW'(1)));
  assign start_ok  = start && ((state_q == StIdle) || (state_q == StErr));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StHdr;
      StHdr:   if (last_byte) state_d = hdr_bad ? StErr : StData;
      StData:  if (last_byte) state_d = StWrite;
      StWrite: state_d = last_word ? StDone : StData;
      StDone:  state_d = StIdle;
      StErr:   if (start) state_d = StHdr;
      default: state_d = StIdle;
    endcase
  end

  // Output logic, registered so every output is a clean flop aligned with the state
  always_comb begin
    byte_ready_d = (state_d == StHdr) || (state_d == StData);
    rom_we_d     = (state_d == StWrite);
    rom_waddr_d  = rom_we_d ? word_cnt_q[ADDR_W-1:0] : rom_waddr_q;
    rom_wdata_d  = rom_we_d ? asm_word : rom_wdata_q;
    done_d       = (state_d == StDone);
    err_d        = (state_d == StErr);
    core_hold_d  = core_hold_q;
    if (state_q == StDone) begin
      core_hold_d = 1'b0;
    end
    if ((state_d == StHdr) || (state_d == StErr)) begin
      core_hold_d = 1'b1;
    end
  end

  // Datapath next-state: byte/word counters, shift register and length
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    if (start_ok) begin
      byte_cnt_d = '0;
    end else if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = asm_word;
    end
    if ((state_q == StHdr) && last_byte) begin
      len_d      = asm_word[CntW-1:0];
      word_cnt_d = '0;
    end
    if ((state_q == StWrite) && !last_word) begin
      word_cnt_d = word_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      rom_we_q     <= 1'b0;
      rom_waddr_q  <= '0;
      rom_wdata_q  <= '0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_ready_q <= byte_ready_d;
      rom_we_q     <= rom_we_d;
      rom_waddr_q  <= rom_waddr_d;
      rom_wdata_q  <= rom_wdata_d;
      core_hold_q  <= core_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign rom_we     = rom_we_q;
  assign rom_waddr  = rom_waddr_q;
  assign rom_wdata  = rom_wdata_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: randomized byte streams checked against a
// word-list model of the expected ROM writes.
module tb_rom_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              core_hold;
  logic              done;
  logic              err;

  rom_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .rom_we     (rom_we),
    .rom_waddr  (rom_waddr),
    .rom_wdata  (rom_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          both_cnt = 0;
  int          exp_done = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] exp_w[$];
  int          got_a[$];
  logic [31:0] got_d[$];

  // Write/pulse collector
  always @(negedge clk) begin
    if (rom_we) begin
      got_a.push_back(int'(rom_waddr));
      got_d.push_back(rom_wdata);
    end
    if (done) done_cnt++;
    if (done && err) both_cnt++;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Frame: LE count, then the words of exp_w[0..nwords-1]
  task automatic build(input int len, input int nwords);
    logic [31:0] w;
    tx_q.delete();
    for (int k = 0; k < 4; k++) tx_q.push_back(8'(len >> (8 * k)));
    for (int i = 0; i < nwords; i++) begin
      w = exp_w[i];
      for (int k = 0; k < 4; k++) tx_q.push_back(w[8*k +: 8]);
    end
  endtask

  task automatic send_stream(input int max_gap);
    while (tx_q.size() > 0) begin : one_byte
      int gap;
      int n;
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (gap) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = tx_q.pop_front();
      n = 0;
      while (!byte_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!byte_ready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stream_stall: byte_ready=%0b required 1 within 100 cycles", byte_ready);
        byte_valid = 1'b0;
        tx_q.delete();
        return;
      end
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (done) begin
        seen = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [48:0] obs;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    obs = {byte_ready, rom_we, rom_waddr, rom_wdata, core_hold, done, err};
    n_cmp++;
    if (obs !== {2'b00, 12'h0, 32'h0, 3'b100})
      begin n_fail++; $display("FAIL reset_values: got %h required %h", obs, {2'b00, 12'h0, 32'h0, 3'b100}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %0b required 0", byte_ready); end
  endtask

  task automatic test_single();
    bit seen;
    got_a.delete(); got_d.delete(); exp_w.delete();
    exp_w.push_back(32'h00000E13);
    build(1, 1);
    pulse_start();
    send_stream(0);
    wait_done(seen);
    exp_done++;
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL single_done: got 0 required 1"); end
    n_cmp++;
    if (core_hold !== 1'b1) begin n_fail++; $display("FAIL hold_at_done: got %0b required 1", core_hold); end
    @(negedge clk);
    n_cmp++;
    if (core_hold !== 1'b0) begin n_fail++; $display("FAIL hold_after_done: got %0b required 0", core_hold); end
    n_cmp++;
    if (got_a.size() != 1 || got_a[0] != 0 || got_d[0] !== 32'h00000E13)
      begin n_fail++; $display("FAIL single_write: got %0d writes (first %h) required 1 write 00000e13", got_a.size(), (got_d.size() > 0) ? got_d[0] : 32'h0); end
  endtask

  task automatic test_gaps();
    bit seen;
    int bad;
    got_a.delete(); got_d.delete(); exp_w.delete();
    exp_w.push_back(32'h00000E13); exp_w.push_back(32'h00100E93); exp_w.push_back(32'h01DE0DB3);
    build(3, 3);
    pulse_start();
    send_stream(4);
    wait_done(seen);
    exp_done++;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL gaps_done: got 0 required 1"); end
    n_cmp++;
    if (got_a.size() != 3) begin n_fail++; $display("FAIL gaps_count: got %0d required 3", got_a.size()); end
    bad = 0;
    for (int i = 0; i < got_a.size() && i < 3; i++) if (got_a[i] != i || got_d[i] !== exp_w[i]) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL gaps_data: got %0d bad writes required 0", bad); end
  endtask

  task automatic test_bad_header();
    int lens[2];
    int rdy_bad;
    bit seen;
    lens[0] = 0; lens[1] = DEPTH + 1;
    for (int t = 0; t < 2; t++) begin
      got_a.delete(); got_d.delete(); exp_w.delete();
      build(lens[t], 0);
      pulse_start();
      send_stream(2);
      n_cmp++;
      if ({err, core_hold, byte_ready} !== 3'b110)
        begin n_fail++; $display("FAIL bad_hdr_%0d: got err/hold/ready=%b required 110", lens[t], {err, core_hold, byte_ready}); end
      byte_valid = 1'b1; byte_data = 8'hAA;
      rdy_bad = 0;
      repeat (6) begin @(negedge clk); if (byte_ready !== 1'b0 || err !== 1'b1) rdy_bad++; end
      byte_valid = 1'b0;
      n_cmp++;
      if (rdy_bad != 0) begin n_fail++; $display("FAIL err_sticky: got %0d bad cycles required 0", rdy_bad); end
      n_cmp++;
      if (got_a.size() != 0) begin n_fail++; $display("FAIL err_no_write: got %0d writes required 0", got_a.size()); end
    end
    exp_w.push_back($urandom);
    build(1, 1);
    pulse_start();
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %0b required 0", err); end
    send_stream(1);
    wait_done(seen);
    exp_done++;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!seen || got_a.size() != 1 || got_d[0] !== exp_w[0])
      begin n_fail++; $display("FAIL recover_load: got done=%0b writes=%0d required done=1 writes=1", seen, got_a.size()); end
  endtask

  task automatic test_full();
    bit seen;
    int bad;
    got_a.delete(); got_d.delete(); exp_w.delete();
    for (int i = 0; i < DEPTH; i++) exp_w.push_back($urandom);
    build(DEPTH, DEPTH);
    pulse_start();
    send_stream(0);
    wait_done(seen);
    exp_done++;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL full_done: got 0 required 1"); end
    n_cmp++;
    if (got_a.size() != DEPTH) begin n_fail++; $display("FAIL full_count: got %0d required %0d", got_a.size(), DEPTH); end
    n_cmp++;
    if (got_a.size() == 0 || got_a[got_a.size()-1] != DEPTH - 1)
      begin n_fail++; $display("FAIL full_last_addr: got %0d required %0d", (got_a.size() > 0) ? got_a[got_a.size()-1] : -1, DEPTH - 1); end
    bad = 0;
    for (int i = 0; i < got_a.size() && i < DEPTH; i++) if (got_a[i] != i || got_d[i] !== exp_w[i]) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL full_data: got %0d bad writes required 0", bad); end
  endtask

  task automatic test_abort();
    logic [48:0] obs;
    bit seen;
    int bad;
    got_a.delete(); got_d.delete(); exp_w.delete();
    exp_w.push_back($urandom); exp_w.push_back($urandom);
    build(2, 2);
    while (tx_q.size() > 6) void'(tx_q.pop_back());
    pulse_start();
    send_stream(1);
    rst = 1'b1;
    @(negedge clk);
    obs = {byte_ready, rom_we, rom_waddr, rom_wdata, core_hold, done, err};
    n_cmp++;
    if (obs !== {2'b00, 12'h0, 32'h0, 3'b100})
      begin n_fail++; $display("FAIL abort_values: got %h required %h", obs, {2'b00, 12'h0, 32'h0, 3'b100}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (got_a.size() != 0) begin n_fail++; $display("FAIL abort_no_write: got %0d required 0", got_a.size()); end
    exp_w.delete();
    exp_w.push_back($urandom); exp_w.push_back($urandom);
    build(2, 2);
    pulse_start();
    send_stream(2);
    wait_done(seen);
    exp_done++;
    repeat (2) @(negedge clk);
    bad = (got_a.size() == 2) ? 0 : 1;
    for (int i = 0; i < got_a.size() && i < 2; i++) if (got_a[i] != i || got_d[i] !== exp_w[i]) bad++;
    n_cmp++;
    if (!seen || bad != 0) begin n_fail++; $display("FAIL abort_reload: got done=%0b bad=%0d required done=1 bad=0", seen, bad); end
  endtask

  task automatic test_restart_ignored();
    logic [7:0] rest_q[$];
    bit seen;
    int bad;
    got_a.delete(); got_d.delete(); exp_w.delete();
    for (int i = 0; i < 3; i++) exp_w.push_back($urandom);
    build(3, 3);
    while (tx_q.size() > 7) rest_q.push_front(tx_q.pop_back());
    pulse_start();
    send_stream(1);
    pulse_start();
    tx_q = rest_q;
    send_stream(1);
    wait_done(seen);
    exp_done++;
    repeat (2) @(negedge clk);
    bad = (got_a.size() == 3) ? 0 : 1;
    for (int i = 0; i < got_a.size() && i < 3; i++) if (got_a[i] != i || got_d[i] !== exp_w[i]) bad++;
    n_cmp++;
    if (!seen || bad != 0) begin n_fail++; $display("FAIL restart_ignored: got done=%0b bad=%0d writes=%0d required done=1 bad=0", seen, bad, got_a.size()); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int bad;
    int len;
    for (int r = 0; r < 4; r++) begin
      got_a.delete(); got_d.delete(); exp_w.delete();
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) exp_w.push_back($urandom);
      build(len, len);
      pulse_start();
      send_stream(2);
      wait_done(seen);
      exp_done++;
      repeat (2) @(negedge clk);
      bad = (got_a.size() == len) ? 0 : 1;
      for (int i = 0; i < got_a.size() && i < len; i++) if (got_a[i] != i || got_d[i] !== exp_w[i]) bad++;
      n_cmp++;
      if (!seen || bad != 0) begin n_fail++; $display("FAIL b2b_%0d len %0d: got done=%0b bad=%0d required done=1 bad=0", r, len, seen, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_bad_header();
    test_full();
    test_abort();
    test_restart_ignored();
    test_back_to_back();
    @(negedge clk);
    n_cmp++;
    if (done_cnt != exp_done) begin n_fail++; $display("FAIL done_pulses: got %0d required %0d", done_cnt, exp_done); end
    n_cmp++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL done_and_err: got %0d required 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
